serial_addsub: RTL
==================

// Module: serial_addsub
// PURPOSE
//  Parametrised digit-serial adder/subtractor; processes DIGIT bits per clock over WIDTH/DIGIT cycles.
//  Trades latency for area: a single DIGIT-bit ripple slice is reused every cycle.
//  Valid/ready handshake on both sides; one operation in flight at a time.
//  Reports carry-out and signed overflow. Add or subtract is selected per operation.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; must be >= 2
//  DIGIT  1  bits added per cycle; WIDTH % DIGIT == 0 (elaboration-time assertion)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operands a, b, cin, sub are valid
//  in_ready   out  1      block can accept an operation
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when sub=1)
//  sub        in   1      0: a+b+cin   1: a-b (computed as a+~b+1)
//  out_valid  out  1      sum/cout/ovf are valid
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry out of the MSB; in sub mode 1 = no borrow
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Clock/reset: single clock; reset is synchronous, active-high, and has priority over all other logic.
//  Reset: state<=IDLE, out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 from the first edge after reset.
//  FSM states: IDLE, RUN, DONE. STEPS = WIDTH/DIGIT.
//   IDLE: in_ready=1. On in_valid&&in_ready: latch a; latch b^{WIDTH{sub}};
//         latch carry=(sub ? 1 : cin); cnt<=STEPS-1; go to RUN.
//   RUN : in_ready=0. Each cycle, add the low DIGIT bits of the A/B shift registers plus carry.
//         Shift A/B right by DIGIT; shift the digit sum into the MSBs of the result register.
//         Update carry. If cnt==0, capture cout/ovf from this digit and go to DONE; else decrement cnt.
//   DONE: out_valid=1; sum/cout/ovf held stable. On out_ready, go to IDLE.
//  Latency: out_valid rises STEPS edges after the accepting edge. Sustained rate is one operation per STEPS+2 cycles.
//  Outputs are registered; in_ready is decoded from state only (no combinational path from out_ready).
//  in_valid is ignored outside IDLE. Operand changes after acceptance have no effect.
//  Backpressure: with out_ready=0, DONE holds indefinitely and the outputs do not change.
//  Reset mid-RUN or in DONE: the operation is abandoned, all reset values apply, and no partial result is emitted.
//  DIGIT==WIDTH: valid degenerate case; one RUN cycle.
// STRUCTURE
//  Package serial_addsub_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} state_t.
//  Sub-module digit_adder #(DIGIT): combinational DIGIT-bit ripple of 1-bit full-adder gate cells.
//   Ports: a, b [DIGIT], ci -> s [DIGIT], co, c_msb (carry into the top bit, used for ovf).
//  Top level: FSM, cnt ($clog2(STEPS+1) bits), A/B/result shift registers, carry flop.
// TESTING (WIDTH=8, DIGIT=1 unless stated)
//  1. a=8'hFF, b=8'h01, cin=0, sub=0 -> sum=8'h00, cout=1, ovf=0; out_valid exactly 8 edges after accept.
//  2. a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, cout=0, ovf=1. Also a=8'h3C, b=8'h0F, cin=1 -> sum=8'h4C, cout=0.
//  3. sub=1: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0, ovf=0. a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
//  4. Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle in_valid with new operands.
//     -> sum/cout/ovf stable, in_ready=0, nothing accepted. After out_ready=1: IDLE, then the next op is accepted.
//  5. Assert reset on the 3rd RUN cycle.
//     -> next cycle: IDLE, out_valid=0, sum=0. A following op 8'h12+8'h34 gives 8'h46.
//  6. DIGIT=4: a=8'h3C, b=8'h0F -> sum=8'h4B, cout=0, out_valid 2 edges after accept.
//     DIGIT=8: same result after 1 edge.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types for the digit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice built from 1-bit full-adder cells.
module digit_adder #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co    = w_c[DIGIT];
  // Carry into the top bit of the slice; only meaningful for the last digit.
  assign c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice reused over WIDTH/DIGIT cycles,
// with valid/ready handshakes and a single operation in flight.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_addsub: WIDTH must be >= 2");
  end
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_addsub: WIDTH must be a multiple of DIGIT");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cout;
  logic               r_ovf;
  logic               r_out_valid;

  logic [DIGIT-1:0]       w_s;
  logic                   w_co;
  logic                   w_c_msb;
  logic [WIDTH+DIGIT-1:0] w_res_cat;
  logic [WIDTH-1:0]       w_res_shift;

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a    (r_a[DIGIT-1:0]),
    .b    (r_b[DIGIT-1:0]),
    .ci   (r_carry),
    .s    (w_s),
    .co   (w_co),
    .c_msb(w_c_msb)
  );

  // New digit enters at the MSB end; also covers DIGIT == WIDTH without an empty slice.
  assign w_res_cat   = {w_s, r_res};
  assign w_res_shift = w_res_cat[WIDTH+DIGIT-1:DIGIT];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b ^ {WIDTH{sub}};
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= CNT_W'(STEPS - 1);
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_res   <= w_res_shift;
          r_carry <= w_co;
          if (r_cnt == '0) begin
            r_cout      <= w_co;
            r_ovf       <= w_c_msb ^ w_co;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign sum       = r_res;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
